// File: rtl/fir_serial_sched.sv
`default_nettype none
// ============================================================================
// Module   : fir_serial_sched
// Brief    : 8-tap serial FIR, one shared multiplier, IDLE/MAC/OUT schedule.
//            Define FIR_SYM_FOLD_EN to fold symmetric taps (4 MAC edges).
// Revision : 1.0  initial release
// ============================================================================
module fir_serial_sched (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] filter_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [32:0] filter_out,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

`ifdef FIR_SYM_FOLD_EN
    localparam logic [2:0] LAST_IDX = 3'd3;
`else
    localparam logic [2:0] LAST_IDX = 3'd7;
`endif

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic signed [32:0] acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic signed [15:0] x_q [8];
    logic signed [15:0] x_d [8];

    logic signed [15:0] coef;
    logic signed [32:0] term;

    function automatic logic signed [15:0] coef_at(input logic [2:0] i);
        case (i)
            3'd0:    coef_at = 16'shDDBB;
            3'd1:    coef_at = 16'shEA8E;
            3'd2:    coef_at = 16'sh33DB;
            3'd3:    coef_at = 16'sh6808;
            3'd4:    coef_at = 16'sh6808;
            3'd5:    coef_at = 16'sh33DB;
            3'd6:    coef_at = 16'shEA8E;
            default: coef_at = 16'shDDBB;
        endcase
    endfunction

`ifdef FIR_SYM_FOLD_EN
    logic signed [16:0] pair;

    // Folded products stay exact, so results match the unfolded schedule.
    always_comb begin
        coef = coef_at(idx_q);
        pair = 17'(x_q[idx_q]) + 17'(x_q[3'd7 - idx_q]);
        term = 33'(pair) * 33'(coef);
    end
`else
    logic signed [31:0] prod;

    // |coef| < 2^15, so the product always fits in 31 signed bits.
    always_comb begin
        coef = coef_at(idx_q);
        prod = 32'(x_q[idx_q]) * 32'(coef);
        term = 33'(prod);
    end
`endif

    assign in_ready   = reset && clk_enable && (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign filter_out = acc_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        for (int k = 0; k < 8; k++) begin
            x_d[k] = x_q[k];
        end

        if (clk_enable) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        x_d[0] = filter_in;
                        for (int k = 1; k < 8; k++) begin
                            x_d[k] = x_q[k-1];
                        end
                        acc_d   = '0;
                        idx_d   = 3'd0;
                        busy_d  = 1'b1;
                        state_d = S_MAC;
                    end
                end
                S_MAC: begin
                    acc_d = acc_q + term;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
                        idx_d       = 3'd0;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            for (int k = 0; k < 8; k++) begin
                x_q[k] <= x_d[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_serial_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_serial_sched
// Brief    : Directed bench for fir_serial_sched with a sum-of-products model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fir_serial_sched;

`ifdef FIR_SYM_FOLD_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 8;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               clk_enable = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] filter_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [32:0] filter_out;
    logic               busy;

    int tests = 0;
    int fails = 0;

    fir_serial_sched dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .filter_in  (filter_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .filter_out (filter_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: delay line plus a countdown of enabled edges.
    int     cf [8] = '{-8773, -5490, 13275, 26632, 26632, 13275, -5490, -8773};
    int     mx [8] = '{default: 0};
    bit     m_idle = 1'b1;
    bit     m_outv = 1'b0;
    int     m_wait = 0;
    longint m_exp  = 0;
    longint m_fo   = 0;
    longint got [$];

    function automatic longint model_y();
        longint s = 0;
        for (int k = 0; k < 8; k++) begin
            longint p = longint'(mx[k]) * longint'(cf[k]);
            p = (p <<< 33) >>> 33;
            s = s + p;
        end
        return (s <<< 31) >>> 31;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 8; k++) mx[k] = 0;
            m_idle = 1'b1;
            m_outv = 1'b0;
            m_wait = 0;
            m_fo   = 0;
        end else if (clk_enable) begin
            if (m_outv) begin
                if (out_ready) begin
                    m_outv = 1'b0;
                    m_idle = 1'b1;
                end
            end else if (!m_idle) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_outv = 1'b1;
                    m_fo   = m_exp;
                end
            end else if (in_valid) begin
                for (int k = 7; k > 0; k--) mx[k] = mx[k-1];
                mx[0]  = int'(filter_in);
                m_exp  = model_y();
                m_wait = LAT;
                m_idle = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset && clk_enable && out_valid && out_ready)
            got.push_back(longint'(filter_out));
    end

    always @(negedge clk) begin
        chk("out_valid", longint'(out_valid), longint'(m_outv));
        chk("busy", longint'(busy), longint'(!m_idle));
        chk("in_ready", longint'(in_ready), longint'(reset && m_idle && clk_enable));
        if (m_outv || !reset)
            chk("filter_out", longint'(filter_out), m_fo);
    end

    task automatic send(input logic [15:0] s);
        int n = 0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        filter_in = s;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        filter_in = 16'h5A5A;
    endtask

    task automatic wait_xfer(input int prev);
        int n = 0;
        while (got.size() <= prev && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_seen", longint'(got.size() > prev), 1);
    endtask

    task automatic send_and_wait(input logic [15:0] s);
        int prev = got.size();
        send(s);
        wait_xfer(prev);
    endtask

    task automatic count_to_valid(inout int n);
        int guard = 0;
        do begin
            @(posedge clk);
            n++;
            guard++;
            @(negedge clk);
        end while (!out_valid && guard < 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        longint imp [8];
        imp = '{-287464891, -179890830, 434981925, 872650744,
                872650744, 434981925, -179890830, -287464891};

        #2 reset = 1'b0;
        #1;
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_filter_out", longint'(filter_out), 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;

        // Impulse response walks out the coefficients.
        base = got.size();
        send_and_wait(16'h7FFF);
        for (int i = 0; i < 7; i++) send_and_wait(16'h0000);
        for (int i = 0; i < 8; i++)
            chk($sformatf("impulse_%0d", i), got[base+i], imp[i]);

        // DC: last output has a full window and the nominal latency.
        for (int i = 0; i < 7; i++) send_and_wait(16'h4000);
        base = got.size();
        send(16'h4000);
        n = 0;
        count_to_valid(n);
        chk("dc_latency", n, LAT);
        wait_xfer(base);
        chk("dc_value", got[base], 840302592);

        for (int i = 0; i < 8; i++) send_and_wait(16'h8000);
        chk("extreme_value", got[got.size()-1], -1680605184);

        // Backpressure: result held, no new input accepted.
        @(posedge clk); #1 out_ready = 1'b0;
        base = got.size();
        send(16'h1234);
        n = 0;
        count_to_valid(n);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", longint'(out_valid), 1);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_data", longint'(filter_out), m_fo);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("bp_one_xfer", got.size() - base, 1);

        // Stall three cycles mid-MAC.
        base = got.size();
        send(16'h2000);
        n = 0;
        repeat (2) begin @(posedge clk); n++; end
        #1 clk_enable = 1'b0;
        repeat (3) begin @(posedge clk); n++; end
        #1 clk_enable = 1'b1;
        count_to_valid(n);
        chk("stall_latency", n, LAT + 3);
        wait_xfer(base);

        // Reset mid-MAC at idx 3 drops the in-flight result.
        base = got.size();
        send(16'h7FFF);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_filter_out", longint'(filter_out), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_xfer", got.size() - base, 0);
        send_and_wait(16'h7FFF);
        chk("post_rst_impulse", got[got.size()-1], -287464891);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
